fetch_stage: RTL

Fetch stage of the pipelined Y86-64 core. It holds the F pipeline register (predicted PC) and selects the fetch PC from the predicted PC, a mispredicted-branch recovery from M, or a return address from W. It splits the 10-byte instruction window returned by instruction memory into fields, computes valP and the next predicted PC, and loads the D pipeline register under stall/bubble control from the hazard unit.

---
 rtl/y86_pkg.sv | 52 +++++
 rtl/fetch_align.sv | 55 +++++
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: icodes, status codes, register sentinel, D-register layout and bubble value.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] FNONE   = 4'h0;

  typedef enum logic [2:0] {
    AOK = 3'd1,
    HLT = 3'd2,
    ADR = 3'd3,
    INS = 3'd4
  } stat_e;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } d_reg_t;

  localparam d_reg_t D_BUBBLE = '{
    stat:  AOK,
    icode: INOP,
    ifun:  FNONE,
    rA:    RNONE,
    rB:    RNONE,
    valC:  64'd0,
    valP:  64'd0
  };

  // Byte length from the two format flags; invalid icodes carry neither flag and end up at 1.
  function automatic logic [3:0] instr_len(input logic has_regids, input logic has_valc);
    return 4'd1 + {3'd0, has_regids} + (has_valc ? 4'd8 : 4'd0);
  endfunction

endpackage

// File: rtl/fetch_align.sv
// Combinational split of the 10-byte fetch window into Y86-64 fields, plus valP.
module fetch_align
  import y86_pkg::*;
(
  input  logic [79:0] instr,
  input  logic [63:0] f_pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        need_regids,
  output logic        need_valC,
  output logic        instr_valid
);

  logic [3:0] w_len;

  assign icode       = instr[7:4];
  assign ifun        = instr[3:0];
  assign instr_valid = (icode <= IPOPQ);

  always_comb begin
    need_regids = 1'b0;
    need_valC   = 1'b0;
    case (icode)
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: need_regids = 1'b1;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        need_regids = 1'b1;
        need_valC   = 1'b1;
      end
      IJXX, ICALL: need_valC = 1'b1;
      default: begin
        need_regids = 1'b0;
        need_valC   = 1'b0;
      end
    endcase
  end

  assign rA = need_regids ? instr[15:12] : RNONE;
  assign rB = need_regids ? instr[11:8]  : RNONE;

  // The constant starts right after the register byte when there is one, else after the opcode.
  always_comb begin
    valC = 64'd0;
    if (need_valC) begin
      valC = need_regids ? instr[79:16] : instr[71:8];
    end
  end

  assign w_len = instr_len(need_regids, need_valC);
  assign valP  = f_pc + {60'd0, w_len};

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, F predicted-PC register, status, and the D pipeline register.
// Define FETCH_PERF_EN to add fetched/mispredict/ret event counters.
module fetch_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] instr,
  input  logic        imem_error,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  output logic [63:0] f_pc,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_mispredict,
  output logic [31:0] perf_ret
`endif
);

  logic [63:0] r_pred_pc;
  d_reg_t      r_d;

  logic        w_sel_mispredict;
  logic        w_sel_ret;
  logic [3:0]  w_icode;
  logic [3:0]  w_ifun;
  logic [3:0]  w_rA;
  logic [3:0]  w_rB;
  logic [63:0] w_valC;
  logic [63:0] w_valP;
  logic        w_need_regids;
  logic        w_need_valC;
  logic        w_instr_valid;
  logic [63:0] w_pred_pc;
  stat_e       w_stat;
  d_reg_t      w_fetched;

  // A not-taken jxx in M means we predicted wrong; it outranks a ret in W.
  assign w_sel_mispredict = (M_icode == IJXX) && !M_cnd;
  assign w_sel_ret        = !w_sel_mispredict && (W_icode == IRET);

  always_comb begin
    f_pc = r_pred_pc;
    if (w_sel_mispredict) begin
      f_pc = M_valA;
    end else if (w_sel_ret) begin
      f_pc = W_valM;
    end
  end

  fetch_align u_align (
    .instr       (instr),
    .f_pc        (f_pc),
    .icode       (w_icode),
    .ifun        (w_ifun),
    .rA          (w_rA),
    .rB          (w_rB),
    .valC        (w_valC),
    .valP        (w_valP),
    .need_regids (w_need_regids),
    .need_valC   (w_need_valC),
    .instr_valid (w_instr_valid)
  );

  // A constant without a register byte is exactly jxx/call: predict taken to valC.
  assign w_pred_pc = (w_need_valC && !w_need_regids) ? w_valC : w_valP;

  always_comb begin
    w_stat = AOK;
    if (imem_error) begin
      w_stat = ADR;
    end else if (!w_instr_valid) begin
      w_stat = INS;
    end else if (w_icode == IHALT) begin
      w_stat = HLT;
    end
  end

  always_comb begin
    w_fetched       = D_BUBBLE;
    w_fetched.stat  = w_stat;
    w_fetched.icode = w_icode;
    w_fetched.ifun  = w_ifun;
    w_fetched.rA    = w_rA;
    w_fetched.rB    = w_rB;
    w_fetched.valC  = w_valC;
    w_fetched.valP  = w_valP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pred_pc <= RESET_PC;
    end else if (!F_stall) begin
      r_pred_pc <= w_pred_pc;
    end
  end

  // Stall outranks bubble so a held instruction is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d <= D_BUBBLE;
    end else if (D_stall) begin
      r_d <= r_d;
    end else if (D_bubble) begin
      r_d <= D_BUBBLE;
    end else begin
      r_d <= w_fetched;
    end
  end

  assign D_stat  = r_d.stat;
  assign D_icode = r_d.icode;
  assign D_ifun  = r_d.ifun;
  assign D_rA    = r_d.rA;
  assign D_rB    = r_d.rB;
  assign D_valC  = r_d.valC;
  assign D_valP  = r_d.valP;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_mispredict;
  logic [31:0] r_perf_ret;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched    <= 32'd0;
      r_perf_mispredict <= 32'd0;
      r_perf_ret        <= 32'd0;
    end else begin
      if (!D_stall && !D_bubble) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_sel_mispredict) begin
        r_perf_mispredict <= r_perf_mispredict + 32'd1;
      end
      if (w_sel_ret) begin
        r_perf_ret <= r_perf_ret + 32'd1;
      end
    end
  end

  assign perf_fetched    = r_perf_fetched;
  assign perf_mispredict = r_perf_mispredict;
  assign perf_ret        = r_perf_ret;
`endif

endmodule
